// File: rtl/dds_func_gen.sv
// dds_func_gen: multi-channel DDS function generator with shadow/commit config; define AMP_SCALE_EN for per-channel amplitude scaling
module dds_func_gen #(
  parameter int NUM_CH = 2,
  parameter int ACC_W = 32,
  parameter int OUT_W = 8,
  parameter int LUT_AW = 8,
  parameter int PAT_W = 16,
  localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          ch_en,
  input  logic                       cfg_we,
  input  logic [CW-1:0]              cfg_ch,
  input  logic [2:0]                 cfg_sel,
  input  logic [31:0]                cfg_wdata,
  input  logic [NUM_CH-1:0]          cfg_commit,
  input  logic                       sync_start,
  output logic [NUM_CH*LUT_AW-1:0]   lut_addr,
  input  logic [NUM_CH*OUT_W-1:0]    lut_data,
  output logic [NUM_CH*OUT_W-1:0]    wave_out,
  output logic [NUM_CH-1:0]          commit_pend
);
  localparam int PW = $clog2(PAT_W);
  localparam logic [2:0] M_SINE = 3'd0, M_TRI = 3'd1, M_SQ = 3'd2, M_PWM = 3'd3, M_PAT = 3'd4, M_DC = 3'd5;
  typedef struct packed {
    logic [2:0]       mode;
    logic [ACC_W-1:0] freq;
    logic [7:0]       duty;
    logic [PAT_W-1:0] pat;
    logic [ACC_W-1:0] poff;
  } cfg_t;
  localparam cfg_t CFG_RST = '{mode: M_SINE, freq: '0, duty: 8'h80, pat: '0, poff: '0};
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    cfg_t shd, act;
    logic [ACC_W-1:0] acc, sum, ph;
    logic [OUT_W:0] t;
    logic [OUT_W-1:0] tri_w, raw, raw_d, smp, wave;
    logic [2:0] mode_d;
    logic carry, arm, xfer, wr, pend, en_d, unused_ok;
    assign {carry, sum} = {1'b0, acc} + {1'b0, act.freq};
    assign ph = acc + act.poff;
    assign t = ph[ACC_W-1 -: OUT_W+1];
    assign tri_w = t[OUT_W] ? ~t[OUT_W-1:0] : t[OUT_W-1:0];
    assign arm = pend | cfg_commit[c];
    assign xfer = arm & (~ch_en[c] | carry);
    assign wr = cfg_we & (cfg_ch == CW'(c));
    assign lut_addr[c*LUT_AW +: LUT_AW] = ph[ACC_W-1 -: LUT_AW];
    assign commit_pend[c] = pend;
    assign wave_out[c*OUT_W +: OUT_W] = wave;
    assign smp = mode_d == M_SINE ? lut_data[c*OUT_W +: OUT_W] : raw_d;
    always_comb
      raw = act.mode == M_TRI ? tri_w :
            act.mode == M_SQ  ? {OUT_W{~ph[ACC_W-1]}} :
            act.mode == M_PWM ? {OUT_W{ph[ACC_W-1 -: 8] < act.duty}} :
            act.mode == M_PAT ? {OUT_W{act.pat[ph[ACC_W-1 -: PW]]}} :
            act.mode == M_DC  ? {1'b1, {(OUT_W-1){1'b0}}} : '0;
    always_ff @(posedge clk) begin
      if (rst) begin
        acc <= '0;
        shd <= CFG_RST;
        act <= CFG_RST;
        pend <= 1'b0;
        en_d <= 1'b0;
        mode_d <= M_SINE;
        raw_d <= '0;
      end else begin
        acc <= (sync_start || !ch_en[c]) ? '0 : sum;
        pend <= arm & ~xfer;
        if (xfer) act <= shd;
        if (wr && cfg_sel == 3'd0 && cfg_wdata[2:0] <= M_DC) shd.mode <= cfg_wdata[2:0];
        if (wr && cfg_sel == 3'd1) shd.freq <= ACC_W'(cfg_wdata);
        if (wr && cfg_sel == 3'd2) shd.duty <= cfg_wdata[7:0];
        if (wr && cfg_sel == 3'd3) shd.pat <= PAT_W'(cfg_wdata);
        if (wr && cfg_sel == 3'd4) shd.poff <= ACC_W'(cfg_wdata);
        en_d <= ch_en[c];
        mode_d <= act.mode;
        raw_d <= raw;
      end
    end
`ifdef AMP_SCALE_EN
    logic [7:0] shd_amp, act_amp, amp_d, amp_q;
    logic [OUT_W-1:0] s2;
    logic [OUT_W+7:0] prod;
    assign prod = (OUT_W+8)'(s2) * (OUT_W+8)'(amp_q);
    assign unused_ok = &{1'b0, ph, prod[7:0]};
    always_ff @(posedge clk) begin
      if (rst) begin
        shd_amp <= 8'hFF;
        act_amp <= 8'hFF;
        amp_d <= 8'hFF;
        amp_q <= 8'hFF;
        s2 <= '0;
        wave <= '0;
      end else begin
        if (wr && cfg_sel == 3'd5) shd_amp <= cfg_wdata[7:0];
        if (xfer) act_amp <= shd_amp;
        amp_d <= act_amp;
        amp_q <= amp_d;
        s2 <= en_d ? smp : '0;
        wave <= amp_q == 8'hFF ? s2 : prod[OUT_W+7:8];
      end
    end
`else
    assign unused_ok = &{1'b0, ph};
    always_ff @(posedge clk) begin
      if (rst) wave <= '0;
      else wave <= en_d ? smp : '0;
    end
`endif
  end
endmodule

// File: doc/dds_func_gen.md
Name: dds_func_gen

Overview:
Multi-channel, parametrised direct-digital-synthesis function generator. It is the successor to the single-channel counter-based generator. Each channel has a phase accumulator driven by a frequency tuning word, with per-channel mode, duty, pattern and phase offset. Channels sit behind a shadow/commit config interface, so updates take effect glitch-free. Sine samples come from an external ROM, one read port per channel. Outputs feed the DAC/PMOD driver.

Parameters:
NUM_CH, 2, number of independent channels
ACC_W, 32, phase accumulator / tuning word width
OUT_W, 8, sample width per channel
LUT_AW, 8, sine ROM address width (full-wave table, 2^LUT_AW entries)
PAT_W, 16, pattern length in bits (power of 2, >=2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
ch_en  in  NUM_CH  per-channel run enable
cfg_we  in  1  config write strobe
cfg_ch  in  $clog2(NUM_CH) (min 1)  target channel
cfg_sel  in  3  0=mode 1=freq_word 2=duty 3=pattern 4=phase_offset 5=amplitude
cfg_wdata  in  32  write data (LSBs used)
cfg_commit  in  NUM_CH  per-channel commit pulse, shadow -> active
sync_start  in  1  realign all accumulators
lut_addr  out  NUM_CH*LUT_AW  sine ROM addresses
lut_data  in  NUM_CH*OUT_W  ROM data, valid 1 cycle after lut_addr
wave_out  out  NUM_CH*OUT_W  channel samples
commit_pend  out  NUM_CH  commit armed, not yet applied

Behaviour:
- Reset: accumulators 0. Shadow and active regs: mode=SINE(0), freq_word=0, duty=0x80, pattern=0, phase_offset=0, amplitude=0xFF. wave_out=0, lut_addr=0, commit_pend=0.
- Modes: 0 SINE, 1 TRIANGLE, 2 SQUARE, 3 PWM, 4 PATTERN, 5 DC (constant midscale, 2^(OUT_W-1)).
  - Mode writes of 6 or 7 are ignored; the shadow keeps its old value.
- Config writes go to shadow regs only. Same-cycle cfg_we on multiple fields is impossible (single bus).
- Commit:
  - cfg_commit[i] sets commit_pend[i].
  - Active <= shadow on the first cycle the channel-i accumulator wraps (carry out of the add), or immediately if ch_en[i]=0. That same cycle clears commit_pend[i].
  - If cfg_we writes the shadow in the same cycle as the transfer, the transfer takes the pre-write shadow value.
- Accumulator:
  - When ch_en[i]=1: acc <= acc + freq_word (mod 2^ACC_W).
  - When ch_en[i]=0: acc held at 0.
  - sync_start has priority and sets all acc <= 0 in the same cycle.
- Phase: ph = acc + phase_offset (mod 2^ACC_W). Define T = ph[ACC_W-1 -: OUT_W+1].
- Per-mode waveform:
  - SINE: lut_addr = ph[ACC_W-1 -: LUT_AW]; the sample is lut_data.
  - TRIANGLE: T[OUT_W]=0 gives T[OUT_W-1:0]; otherwise ~T[OUT_W-1:0]. Period is 2^(OUT_W+1) steps, peak all-ones.
  - SQUARE: ph MSB=0 gives all-ones, else 0.
  - PWM: all-ones while ph[ACC_W-1 -: 8] < duty, else 0. duty=0 means constant 0.
  - PATTERN: output bit = pattern[ph[ACC_W-1 -: log2(PAT_W)]], LSB first; 1 gives all-ones, 0 gives 0.
- Latency:
  - Fixed 2-cycle pipeline for all modes: the acc value at cycle N appears on wave_out at N+2.
  - Non-sine paths are delayed to match the ROM latency.
  - A mode change never emits a mixed-mode sample.
- ch_en deassert: wave_out reaches 0 two cycles later. Re-enable restarts from phase_offset.
- Reset mid-operation: all state returns to reset values next edge; pending commits are discarded.

Optional Feature:
AMP_SCALE_EN
- Defined:
  - cfg_sel=5 writes a per-channel 8-bit amplitude (shadowed/committed like the other fields).
  - wave_out = (raw * amplitude) >> 8, rounded down; amplitude=0xFF uses raw unchanged.
  - Adds one pipeline stage, so latency is 3 cycles for all modes.
- Undefined: cfg_sel=5 writes are ignored, no multiplier is built, latency stays 2.

Test Plan:
- Square: ch0 freq_word=0x4000_0000, mode=2, commit, ch_en=1 -> wave_out[0] repeats FF,FF,00,00 (period 4 clks), first sample 2 clks after enable.
- PWM: freq_word=0x0100_0000, duty=0x40 -> period 256 clks, exactly 64 clks at 0xFF; duty=0 -> constant 0x00.
- Triangle: freq_word=0x0080_0000 -> ramp 00..FF over 256 clks, then FF..00, period 512. Pattern: pattern=0xA5A5, freq_word=0x1000_0000 -> per-clock bits 1,0,1,0,0,1,0,1,...
- Glitch-free commit: ch0 square running at 0x0400_0000; write freq_word=0x0800_0000 and commit mid-period -> commit_pend=1 until wrap; old period completes, new period 32 clks follows. Mode write 7 -> ignored, waveform unchanged.
- Sine/sync: ROM model with 1-clk latency, phase_offset ch1=0x4000_0000, equal freq_word, sync_start -> lut_addr[1] = lut_addr[0]+0x40 (mod 256) every cycle.
- Reset mid-run, with a commit pending -> next edge wave_out=0, commit_pend=0, active config at defaults; AMP_SCALE_EN build: amplitude=0x80 on square -> 0x7F/0x00 with 3-clk latency.
